// File: rtl/vga_fb_scanout_if.sv
// Framebuffer row-read bus between the scanout (master) and the framebuffer holder (slave).
interface vga_fb_scanout_if;
  logic        fb_rd;
  logic [4:0]  fb_row_addr;
  logic [31:0] fb_row_data;

  modport master (output fb_rd, output fb_row_addr, input fb_row_data);
  modport slave  (input fb_rd, input fb_row_addr, output fb_row_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// 640x480@60 scanout of a 32x32 mono framebuffer, scaled by SCALE and centred; one row fetch per image line.
// Optional: define VGA_FB_SCANOUT_BORDER_EN to draw a 1-pixel fg_rgb frame around the image.
module vga_fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 12,
  parameter int X_OFFSET = 128,
  parameter int Y_OFFSET = 48
) (
  input  logic               clk,
  input  logic               reset,
  vga_fb_scanout_if.master   fb,
  input  logic [2:0]         fg_rgb,
  input  logic [2:0]         bg_rgb,
  output logic [2:0]         rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int IMG     = 32 * SCALE;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_FETCH = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG   = HW'(X_OFFSET);
  localparam logic [HW-1:0] X_END   = HW'(X_OFFSET + IMG);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG   = VW'(Y_OFFSET);
  localparam logic [VW-1:0] Y_END   = VW'(Y_OFFSET + IMG);
  localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);

  if (X_OFFSET + IMG > H_ACTIVE || Y_OFFSET + IMG > V_ACTIVE) begin : g_bad_window
    $error("vga_fb_scanout: image window does not fit in the active area");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_next;
  logic [4:0]    r_q, r_d, c_q, c_d, row_addr_q, row_addr_d, next_row;
  logic [SW-1:0] ys_q, ys_d, xs_q, xs_d;
  logic [31:0]   line_buf_q, line_buf_d;
  logic          fb_rd_q, fb_rd_d, rd_dly_q, rd_dly_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, disp_q, disp_d, fs_q, fs_d;
  logic          h_wrap, v_wrap, in_x, in_y, next_in_y, pix;

`ifdef VGA_FB_SCANOUT_BORDER_EN
  localparam logic [HW-1:0] X_RING = HW'(X_OFFSET - 1);
  localparam logic [VW-1:0] Y_RING = VW'(Y_OFFSET - 1);
  if (X_OFFSET < 1 || Y_OFFSET < 1) begin : g_bad_border
    $error("vga_fb_scanout: border needs X_OFFSET and Y_OFFSET of at least 1");
  end
  logic on_ring;
  always_comb begin
    on_ring = ((h_cnt_q == X_RING || h_cnt_q == X_END) && v_cnt_q >= Y_RING && v_cnt_q <= Y_END) ||
              ((v_cnt_q == Y_RING || v_cnt_q == Y_END) && h_cnt_q >= X_RING && h_cnt_q <= X_END);
  end
`endif

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_next  = v_wrap ? '0 : v_cnt_q + VW'(1);
    v_cnt_d = h_wrap ? v_next : v_cnt_q;
    in_x      = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END);
    in_y      = (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);
    next_in_y = (v_next >= Y_BEG) && (v_next < Y_END);

    // Column/row trackers replace a divide by SCALE; both sit at 0 outside the window.
    c_d  = '0;
    xs_d = '0;
    if (in_x) begin
      if (xs_q == S_LAST) c_d = c_q + 5'd1;
      else begin
        c_d  = c_q;
        xs_d = xs_q + SW'(1);
      end
    end
    r_d  = r_q;
    ys_d = ys_q;
    if (h_wrap) begin
      r_d  = '0;
      ys_d = '0;
      if (in_y) begin
        if (ys_q == S_LAST) r_d = r_q + 5'd1;
        else begin
          r_d  = r_q;
          ys_d = ys_q + SW'(1);
        end
      end
    end

    // Fetch for the next line; the strobe is registered so it is high while h_cnt == H_ACTIVE.
    next_row   = in_y ? ((ys_q == S_LAST) ? r_q + 5'd1 : r_q) : 5'd0;
    fb_rd_d    = (h_cnt_q == H_FETCH) && next_in_y;
    row_addr_d = fb_rd_d ? next_row : row_addr_q;
    rd_dly_d   = fb_rd_q;
    line_buf_d = rd_dly_q ? fb.fb_row_data : line_buf_q;

    disp_d  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    pix     = line_buf_q[5'd31 - c_q];
    rgb_d   = '0;
    if (disp_d) begin
      if (in_x && in_y) rgb_d = pix ? fg_rgb : bg_rgb;
`ifdef VGA_FB_SCANOUT_BORDER_EN
      else if (on_ring) rgb_d = fg_rgb;
`endif
      else rgb_d = bg_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      r_q        <= '0;
      ys_q       <= '0;
      c_q        <= '0;
      xs_q       <= '0;
      row_addr_q <= '0;
      line_buf_q <= '0;
      fb_rd_q    <= 1'b0;
      rd_dly_q   <= 1'b0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      disp_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      r_q        <= r_d;
      ys_q       <= ys_d;
      c_q        <= c_d;
      xs_q       <= xs_d;
      row_addr_q <= row_addr_d;
      line_buf_q <= line_buf_d;
      fb_rd_q    <= fb_rd_d;
      rd_dly_q   <= rd_dly_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      disp_q     <= disp_d;
      fs_q       <= fs_d;
    end
  end

  assign fb.fb_rd       = fb_rd_q;
  assign fb.fb_row_addr = row_addr_q;
  assign rgb            = rgb_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign display_on     = disp_q;
  assign frame_start    = fs_q;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout on a reduced screen geometry (96x77 total, SCALE 2, image at 8,3).
// Frame-level model plus per-frame captures checked against hand-computed values.
module tb_vga_fb_scanout;
  localparam int HA = 80, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 70, VFP = 2, VS = 2, VBP = 3;
  localparam int SC = 2, XO = 8, YO = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 96
  localparam int VT = VA + VFP + VS + VBP;   // 77
  localparam int FRAME = HT * VT;            // 7392
  localparam int IMG = 32 * SC;              // 64

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] fg_rgb, bg_rgb, rgb;
  logic hsync, vsync, display_on, frame_start;
  vga_fb_scanout_if bus();

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SCALE(SC), .X_OFFSET(XO), .Y_OFFSET(YO)
  ) dut (
    .clk(clk), .reset(reset), .fb(bus.master),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .display_on(display_on), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Framebuffer holder: registered row read.
  logic [31:0] fb_mem [32];
  always @(posedge clk) if (bus.fb_rd) bus.fb_row_data <= fb_mem[bus.fb_row_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- screen-level model ----------------
  function automatic bit line_in_img(int v);
    return v >= YO && v < YO + IMG;
  endfunction
  function automatic bit in_win(int h, int v);
    return h >= XO && h < XO + IMG && line_in_img(v);
  endfunction
  function automatic bit on_ring(int h, int v);
    return ((h == XO - 1 || h == XO + IMG) && v >= YO - 1 && v <= YO + IMG) ||
           ((v == YO - 1 || v == YO + IMG) && h >= XO - 1 && h <= XO + IMG);
  endfunction
  function automatic logic [2:0] exp_pix(int h, int v, logic [31:0] lb);
    if (!(h < HA && v < VA)) return 3'd0;
    if (in_win(h, v)) return lb[31 - (h - XO) / SC] ? fg_rgb : bg_rgb;
`ifdef VGA_FB_SCANOUT_BORDER_EN
    if (on_ring(h, v)) return fg_rgb;
`endif
    return bg_rgb;
  endfunction
  function automatic int nh_f(int h);
    return (h + 1) % HT;
  endfunction
  function automatic int nv_f(int h, int v);
    return (h == HT - 1) ? (v + 1) % VT : v;
  endfunction
  function automatic bit fetch_at(int h, int v);
    return h == HA && line_in_img((v + 1) % VT);
  endfunction
  function automatic int fetch_row(int v);
    return ((v + 1) % VT - YO) / SC;
  endfunction

  int mh, mv;                         // screen position being generated this cycle
  logic [2:0] e_rgb;
  logic e_hs, e_vs, e_de, e_fs, e_rd;
  logic [4:0] e_addr;
  logic [31:0] e_buf;                 // row contents the current image line must show
  bit chk_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      mh <= 0; mv <= 0;
      e_rgb <= 3'd0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0;
      e_rd <= 1'b0; e_addr <= 5'd0; e_buf <= 32'd0;
    end else begin
      e_de  <= mh < HA && mv < VA;
      e_hs  <= !(mh >= HA + HFP && mh < HA + HFP + HS);
      e_vs  <= !(mv >= VA + VFP && mv < VA + VFP + VS);
      e_fs  <= mh == 0 && mv == 0;
      e_rgb <= exp_pix(mh, mv, e_buf);
      if (fetch_at(mh, mv)) e_buf <= fb_mem[fetch_row(mv)];
      e_rd <= fetch_at(nh_f(mh), nv_f(mh, mv));
      if (fetch_at(nh_f(mh), nv_f(mh, mv))) e_addr <= 5'(fetch_row(nv_f(mh, mv)));
      mh <= nh_f(mh);
      mv <= nv_f(mh, mv);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rgb", 32'(rgb), 32'(e_rgb));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("display_on", 32'(display_on), 32'(e_de));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("fb_rd", 32'(bus.fb_rd), 32'(e_rd));
      chk("fb_row_addr", 32'(bus.fb_row_addr), 32'(e_addr));
    end
  end

  // ---------------- per-frame capture, indexed from frame_start ----------------
  int cyc = 0, fidx = -1, k = -1;
  int fs_cyc[$];
  logic [2:0] cap_rgb [2][FRAME];
  logic       cap_hs  [2][FRAME];
  logic       cap_vs  [2][FRAME];
  logic       cap_de  [2][FRAME];
  int rd_cnt [2];
  int hist   [2][32];

  always @(negedge clk) begin
    cyc++;
    if (frame_start) begin
      fs_cyc.push_back(cyc);
      fidx++;
      k = 0;
      rd_cnt[fidx % 2] = 0;
      for (int i = 0; i < 32; i++) hist[fidx % 2][i] = 0;
    end else if (k >= 0) k++;
    if (fidx >= 0 && k < FRAME) begin
      cap_rgb[fidx % 2][k] = rgb;
      cap_hs[fidx % 2][k]  = hsync;
      cap_vs[fidx % 2][k]  = vsync;
      cap_de[fidx % 2][k]  = display_on;
      if (bus.fb_rd) begin
        rd_cnt[fidx % 2]++;
        hist[fidx % 2][bus.fb_row_addr]++;
      end
    end
  end

  function automatic logic [2:0] px(int b, int h, int v);
    return cap_rgb[b][v * HT + h];
  endfunction

  task automatic wait_frame(input int n);
    int t = 0;
    while (fidx < n && t < 3 * FRAME) begin @(negedge clk); #1; t++; end
    checks++;
    if (fidx < n) begin errors++; $display("FAIL wait_frame: frame %0d not reached, at %0d", n, fidx); end
  endtask

  task automatic wait_k(input int target);
    int t = 0;
    while (k != target && t < 2 * FRAME) begin @(negedge clk); #1; t++; end
    checks++;
    if (k != target) begin errors++; $display("FAIL wait_k: index %0d not reached, at %0d", target, k); end
  endtask

  task automatic wait_pos(input int h, input int v);
    int t = 0;
    while (!(mh == h && mv == v) && t < 2 * FRAME) begin @(negedge clk); #1; t++; end
    checks++;
    if (!(mh == h && mv == v)) begin errors++; $display("FAIL wait_pos: (%0d,%0d) not reached", h, v); end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_display_on"}, 32'(display_on), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_fb_rd"}, 32'(bus.fb_rd), 32'd0);
    chk({tag, "_fb_row_addr"}, 32'(bus.fb_row_addr), 32'd0);
  endtask

  int rel, cnt, bad;

  initial begin
    fg_rgb = 3'b110;
    bg_rgb = 3'b001;
    for (int i = 0; i < 32; i++) fb_mem[i] = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_en = 1;
    chk_reset_outputs("por");
    reset = 1'b0;
    rel = cyc;

    // Frame 0 (all rows clear) is complete once frame 1 starts; load row 0 for frame 1 now.
    wait_frame(1);
    fb_mem[0] = 32'h8000_0001;
    chk("first_fs_after_release", 32'(fs_cyc[0]), 32'(rel + 1));
    chk("fs_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'd7392);
    cnt = 0; for (int h = 0; h < HT; h++) if (!cap_hs[0][10 * HT + h]) cnt++;
    chk("hsync_low_line10", 32'(cnt), 32'd8);
    cnt = 0; for (int h = 0; h < HT; h++) if (!cap_hs[0][75 * HT + h]) cnt++;
    chk("hsync_low_line75", 32'(cnt), 32'd8);
    cnt = 0; for (int i = 0; i < FRAME; i++) if (!cap_vs[0][i]) cnt++;
    chk("vsync_low_cycles", 32'(cnt), 32'd192);
    chk("vsync_low_line72", 32'(cap_vs[0][72 * HT]), 32'd0);
    chk("fb_rd_per_frame", 32'(rd_cnt[0]), 32'd64);
    bad = 0; for (int i = 0; i < 32; i++) if (hist[0][i] != 2) bad++;
    chk("fb_row_addr_hist", 32'(bad), 32'd0);
    bad = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        if (cap_de[0][v * HT + h] !== (h < HA && v < VA)) bad++;
        else if (!(h < HA && v < VA) && px(0, h, v) !== 3'd0) bad++;
        else if (h < HA && v < VA && !on_ring(h, v) && px(0, h, v) !== 3'b001) bad++;
      end
    chk("f0_pixels_bg_blank0", 32'(bad), 32'd0);
`ifdef VGA_FB_SCANOUT_BORDER_EN
    bad = 0;
    for (int h = XO - 1; h <= XO + IMG; h++) begin
      if (px(0, h, YO - 1) !== 3'b110) bad++;
      if (px(0, h, YO + IMG) !== 3'b110) bad++;
    end
    for (int v = YO; v < YO + IMG; v++) begin
      if (px(0, XO - 1, v) !== 3'b110) bad++;
      if (px(0, XO + IMG, v) !== 3'b110) bad++;
    end
    chk("border_ring_fg", 32'(bad), 32'd0);
    chk("border_outside_bg", 32'(px(0, XO - 2, YO - 1)), 32'(3'b001));
`else
    chk("no_border_left", 32'(px(0, XO - 1, YO + 5)), 32'(3'b001));
    chk("no_border_bottom", 32'(px(0, XO + IMG, YO + IMG)), 32'(3'b001));
`endif

    // Row 5 rewritten during line 11 (row 4, ys 0); it first shows on line 13.
    wait_k(11 * HT + 30);
    fb_mem[5] = 32'hF000_000F;

    wait_frame(2);
    chk("r0_l3_h7", 32'(px(1, 7, 3)), 32'(3'b001));
    chk("r0_l3_h8", 32'(px(1, 8, 3)), 32'(3'b110));
    chk("r0_l3_h9", 32'(px(1, 9, 3)), 32'(3'b110));
    chk("r0_l3_h10", 32'(px(1, 10, 3)), 32'(3'b001));
    chk("r0_l3_h69", 32'(px(1, 69, 3)), 32'(3'b001));
    chk("r0_l3_h70", 32'(px(1, 70, 3)), 32'(3'b110));
    chk("r0_l3_h71", 32'(px(1, 71, 3)), 32'(3'b110));
    chk("r0_l3_h72", 32'(px(1, 72, 3)), 32'(3'b001));
    chk("r0_l4_h8", 32'(px(1, 8, 4)), 32'(3'b110));
    bad = 0; for (int h = 0; h < HA; h++) if (px(1, h, 5) !== 3'b001) bad++;
    chk("r1_l5_all_bg", 32'(bad), 32'd0);
    chk("r4_l12_h8", 32'(px(1, 8, 12)), 32'(3'b001));
    chk("r5_l13_h8", 32'(px(1, 8, 13)), 32'(3'b110));
    chk("r5_l13_h15", 32'(px(1, 15, 13)), 32'(3'b110));
    chk("r5_l13_h16", 32'(px(1, 16, 13)), 32'(3'b001));
    chk("r5_l13_h63", 32'(px(1, 63, 13)), 32'(3'b001));
    chk("r5_l14_h64", 32'(px(1, 64, 14)), 32'(3'b110));
    chk("r5_l14_h71", 32'(px(1, 71, 14)), 32'(3'b110));

    // One-cycle reset in the middle of frame 2.
    wait_pos(40, 30);
    reset = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("midrst");
    reset = 1'b0;
    rel = cyc;
    wait_frame(4);
    chk("fs_after_midrst", 32'(fs_cyc[3]), 32'(rel + 1));
    chk("fs_period_after_midrst", 32'(fs_cyc[4] - fs_cyc[3]), 32'd7392);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
